dccm_responder: RTL and testbench
=================================

# dccm_responder

Data Closely Coupled Memory (DCCM) responder: the memory-side end of the LSU/EXU DCCM port. It serves word reads with a fixed, parameterised latency and single-cycle word writes. It zero-initialises its storage after reset and flags out-of-range or misaligned accesses. It sits beside the core, driven directly by the EXU's `dccm_*` outputs, and returns read data to the LSU load path.

## Interface
- `XLEN`, 32: data and address width.
- `DEPTH_WORDS`, 4096: storage depth in XLEN-bit words (power of two).
- `BASE_ADDR`, 32'h0001_0000: byte address of word 0 (DEPTH_WORDS*4 aligned).
- `RD_LATENCY`, 2: cycles from a read request to `dccm_rvalid_out` (legal 1..4).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dccm_raddr`  in  XLEN  read byte address.
- `dccm_rvalid_in`  in  1  read request strobe, one request per asserted cycle.
- `dccm_rdata`  out  XLEN  read data, valid only while `dccm_rvalid_out`=1.
- `dccm_rvalid_out`  out  1  read response strobe.
- `dccm_waddr`  in  XLEN  write byte address.
- `dccm_wen`  in  1  write strobe; full-word write.
- `dccm_wdata`  in  XLEN  write data.
- `dccm_err`  out  1  access error pulse (see Operation).
- `dccm_init_done`  out  1  high once zero-initialisation has completed.

## Operation
- Address decode: in-range iff `BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS`. Word index = `(addr - BASE_ADDR) >> 2`, truncated to log2(DEPTH_WORDS) bits.
- A misaligned access (`addr[1:0] != 0`) is an error and is treated as out-of-range.
- State machine, two states:
  - INIT (entered on reset): a counter writes 0 to word 0, 1, …, DEPTH_WORDS-1, one word per cycle.
  - RUN: entered the cycle after word DEPTH_WORDS-1 is cleared; `dccm_init_done` rises with entry into RUN and stays high until the next reset.
- Requests during INIT:
  - A write is dropped and raises an error.
  - A read is accepted into the pipeline, returns 0 and raises an error with its response.
- Write in RUN: an in-range write updates the array at the edge it is presented. An out-of-range write is dropped, with no array change.
- Read in RUN: the array is sampled in the request cycle. If an in-range write to the same word is presented in that same cycle, the read returns the new `dccm_wdata` (write-first). Writes in later cycles do not alter an in-flight read.
- A read pipeline of depth `RD_LATENCY` carries valid, data and error. Back-to-back reads every cycle are supported with no bubbles. Reads and writes are independent and may occur in the same cycle at any addresses.
- Error reporting:
  - Read error: `dccm_err` pulses in the same cycle as that read's `dccm_rvalid_out`, and `dccm_rdata` is 0.
  - Write error: `dccm_err` pulses one cycle after the write strobe.
  - Both may coincide; `dccm_err` is the OR of the two.
- `dccm_rdata` is 0 whenever `dccm_rvalid_out`=0.

## Timing
- Reset values: `dccm_rdata`=0, `dccm_rvalid_out`=0, `dccm_err`=0, `dccm_init_done`=0. The pipeline is cleared, the state is INIT and the init counter is 0.
- Reset asserted mid-operation: in-flight reads are discarded, with no response ever issued. Init restarts from word 0 after reset deasserts.
- Init duration: `dccm_init_done` rises exactly DEPTH_WORDS cycles after the first rising edge with `rst`=0.
- Read latency: a request at edge N produces `dccm_rvalid_out`=1 and data during the cycle following edge N+RD_LATENCY-1. RD_LATENCY=1 means data is visible in the cycle immediately after the request edge.
- Write latency: data written at edge N is visible to a read requested at edge N (bypass) or later.
- Throughput: 1 read and 1 write per cycle, sustained.
- No backpressure: the responder never stalls the requester.

## Test plan
- Init: release `rst`, DEPTH_WORDS=16 → `dccm_init_done` rises after 16 cycles. Reads of all 16 words return 0 with `dccm_err`=0.
- Write/read, RD_LATENCY=2: write 32'hDEAD_BEEF to BASE_ADDR+0x8, then read BASE_ADDR+0x8 next cycle → `dccm_rvalid_out` 2 cycles after the request with `dccm_rdata`=32'hDEAD_BEEF.
- Same-cycle collision: old value 32'h1111_1111, then write 32'h2222_2222 and read the same word in one cycle → 32'h2222_2222 returned. A write of 32'h3333_3333 the following cycle does not change that response.
- Streaming: 8 consecutive read strobes to words 0..7 holding values 0x10..0x17 → 8 consecutive `dccm_rvalid_out` cycles returning 0x10..0x17 in order.
- Errors:
  - Read BASE_ADDR+4*DEPTH_WORDS → `dccm_rdata`=0 with `dccm_err` on the response cycle.
  - Write BASE_ADDR+0x2 → `dccm_err` the next cycle and the word is unchanged.
  - A read during INIT → 0 plus `dccm_err`.
- Reset mid-stream: assert `rst` with 2 reads in flight → no `dccm_rvalid_out` after reset. `dccm_init_done`=0 and init restarts from word 0.

Source files
------------

// File: rtl/dccm_if.sv
// dccm_if: EXU/LSU to DCCM request/response bundle.
// master drives requests, slave returns read data and status.
interface dccm_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] dccm_raddr;
  logic            dccm_rvalid_in;
  logic [XLEN-1:0] dccm_rdata;
  logic            dccm_rvalid_out;
  logic [XLEN-1:0] dccm_waddr;
  logic            dccm_wen;
  logic [XLEN-1:0] dccm_wdata;
  logic            dccm_err;
  logic            dccm_init_done;

  modport master (
    output dccm_raddr,
    output dccm_rvalid_in,
    output dccm_waddr,
    output dccm_wen,
    output dccm_wdata,
    input  dccm_rdata,
    input  dccm_rvalid_out,
    input  dccm_err,
    input  dccm_init_done
  );

  modport slave (
    input  dccm_raddr,
    input  dccm_rvalid_in,
    input  dccm_waddr,
    input  dccm_wen,
    input  dccm_wdata,
    output dccm_rdata,
    output dccm_rvalid_out,
    output dccm_err,
    output dccm_init_done
  );
endinterface

// File: rtl/dccm_responder.sv
// dccm_responder: DCCM memory-side responder with fixed read latency,
// single-cycle word writes and zero-initialisation after reset.
module dccm_responder #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned     RD_LATENCY  = 2
) (
  input logic   clk,
  input logic   rst,
  dccm_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN:0] END_ADDR =
    {1'b0, BASE_ADDR} + (XLEN+1)'(4 * DEPTH_WORDS);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   init_cnt_q;
  logic            init_act;
  logic            init_last;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic            r_ok;
  logic            w_ok;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] rd_data;
  logic            rd_err;
  logic            werr_q;

  logic [RD_LATENCY-1:0] pv_q;
  logic [RD_LATENCY-1:0] pe_q;
  logic [XLEN-1:0]       pd_q [RD_LATENCY];

  function automatic logic in_range(
    input logic [XLEN-1:0] a
  );
    return (a[1:0] == 2'b00)
      && ({1'b0, a} >= {1'b0, BASE_ADDR})
      && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [AW-1:0] word_idx(
    input logic [XLEN-1:0] a
  );
    logic [XLEN-1:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (init_last) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    init_act  = (state_q == S_INIT);
    init_last = init_act
      && (init_cnt_q == AW'(DEPTH_WORDS - 1));
    bus.dccm_init_done = (state_q == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           init_cnt_q <= '0;
    else if (init_act) init_cnt_q <= init_cnt_q + 1'b1;
  end

  assign w_ok  = bus.dccm_wen && !init_act
    && in_range(bus.dccm_waddr);
  assign r_ok  = !init_act && in_range(bus.dccm_raddr);
  assign w_idx = word_idx(bus.dccm_waddr);
  assign r_idx = word_idx(bus.dccm_raddr);

  // Storage carries no reset; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (init_act)  mem_q[init_cnt_q] <= '0;
    else if (w_ok) mem_q[w_idx]      <= bus.dccm_wdata;
  end

  always_comb begin
    rd_data = '0;
    if (r_ok) begin
      if (w_ok && (w_idx == r_idx)) rd_data = bus.dccm_wdata;
      else                          rd_data = mem_q[r_idx];
    end
  end

  assign rd_err = bus.dccm_rvalid_in && !r_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= bus.dccm_rvalid_in;
      pe_q[0] <= rd_err;
      pd_q[0] <= bus.dccm_rvalid_in ? rd_data : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) werr_q <= 1'b0;
    else     werr_q <= bus.dccm_wen && !w_ok;
  end

  assign bus.dccm_rvalid_out = pv_q[RD_LATENCY-1];
  assign bus.dccm_rdata = pv_q[RD_LATENCY-1]
    ? pd_q[RD_LATENCY-1] : '0;
  assign bus.dccm_err = (pv_q[RD_LATENCY-1] && pe_q[RD_LATENCY-1])
    || werr_q;
endmodule

// File: tb/tb_dccm_responder.sv
// tb_dccm_responder: scoreboard bench for dccm_responder with
// directed scenarios plus randomized read/write traffic.
module tb_dccm_responder;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 16;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dccm_if #(.XLEN(XLEN)) bus ();

  dccm_responder #(
    .XLEN(XLEN),
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE),
    .RD_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [DEPTH];
  int          init_left = DEPTH;
  logic        mdl_run   = 1'b0;
  logic        exp_werr  = 1'b0;
  int          cyc       = 0;
  int          n_tests   = 0;
  int          n_fail    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic ok(input logic [31:0] a);
    longint unsigned ua;
    ua = 64'(a);
    return (ua % 4 == 0) && (ua >= 64'(BASE))
      && (ua < 64'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
    if (k == 1) return BASE + 4 * $urandom_range(0, DEPTH - 1)
      + $urandom_range(1, 3);
    if (k == 2) return BASE - 4;
    return BASE + 4 * $urandom_range(0, DEPTH - 1);
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h",
               name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic exp_e;
    exp_t e;
    exp_e = exp_werr;
    while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_rvalid: response due cycle %0d absent",
               exp_q[0].c);
      void'(exp_q.pop_front());
    end
    if (bus.dccm_rvalid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rvalid at cycle %0d: got 1, expected 0",
                 cyc);
      end else begin
        e = exp_q.pop_front();
        check("rdata", bus.dccm_rdata, e.d);
        check("rd_latency", cyc, e.c);
        exp_e = exp_e | e.e;
      end
    end else begin
      check("rdata_idle", bus.dccm_rdata, 32'h0);
    end
    check("err", {31'b0, bus.dccm_err}, {31'b0, exp_e});
    check("init_done", {31'b0, bus.dccm_init_done}, {31'b0, mdl_run});
  end

  task automatic idle_inputs();
    bus.dccm_rvalid_in = 1'b0;
    bus.dccm_raddr     = '0;
    bus.dccm_wen       = 1'b0;
    bus.dccm_waddr     = '0;
    bus.dccm_wdata     = '0;
  endtask

  task automatic step(input logic rv, input logic [31:0] ra,
                      input logic we, input logic [31:0] wa,
                      input logic [31:0] wd);
    logic in_init;
    logic werr;
    exp_t e;
    bus.dccm_rvalid_in = rv;
    bus.dccm_raddr     = ra;
    bus.dccm_wen       = we;
    bus.dccm_waddr     = wa;
    bus.dccm_wdata     = wd;
    in_init = (init_left > 0);
    if (rv) begin
      e.c = cyc + LAT;
      e.e = in_init || !ok(ra);
      e.d = 32'h0;
      if (!e.e) begin
        if (we && ok(wa) && idx(wa) == idx(ra)) e.d = wd;
        else e.d = mdl[idx(ra)];
      end
      exp_q.push_back(e);
    end
    werr = we && (in_init || !ok(wa));
    if (we && !werr) mdl[idx(wa)] = wd;
    @(posedge clk);
    exp_werr = werr;
    if (init_left > 0) init_left--;
    mdl_run = (init_left == 0);
    #1;
    idle_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_werr  = 1'b0;
    mdl_run   = 1'b0;
    init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rnd_traffic(input int n);
    repeat (n) begin
      step(1'($urandom_range(0, 1)), rnd_addr(),
           1'($urandom_range(0, 1)), rnd_addr(), $urandom());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    #1;
    do_reset();

    step(1'b1, BASE, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, BASE + 4, 32'hAAAA_5555);
    idle(16);

    for (int i = 0; i < DEPTH; i++) step(1'b1, BASE + 4 * i, 1'b0, '0, '0);

    step(1'b0, '0, 1'b1, BASE + 32'h8, 32'hDEAD_BEEF);
    step(1'b1, BASE + 32'h8, 1'b0, '0, '0);

    step(1'b0, '0, 1'b1, BASE + 32'hC, 32'h1111_1111);
    step(1'b1, BASE + 32'hC, 1'b1, BASE + 32'hC, 32'h2222_2222);
    step(1'b0, '0, 1'b1, BASE + 32'hC, 32'h3333_3333);
    step(1'b1, BASE + 32'hC, 1'b0, '0, '0);

    for (int i = 0; i < 8; i++)
      step(1'b0, '0, 1'b1, BASE + 4 * i, 32'h10 + i);
    for (int i = 0; i < 8; i++) step(1'b1, BASE + 4 * i, 1'b0, '0, '0);

    step(1'b1, BASE + 4 * DEPTH, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, BASE + 32'h2, 32'hFFFF_FFFF);
    step(1'b1, BASE, 1'b0, '0, '0);
    step(1'b1, BASE - 4, 1'b1, BASE + 4 * DEPTH, 32'h1);
    idle(LAT + 1);

    rnd_traffic(400);

    step(1'b1, BASE, 1'b0, '0, '0);
    step(1'b1, BASE + 4, 1'b0, '0, '0);
    do_reset();
    step(1'b1, BASE + 4, 1'b0, '0, '0);
    idle(DEPTH + 2);
    step(1'b1, BASE + 4, 1'b0, '0, '0);
    rnd_traffic(150);
    idle(LAT + 2);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0",
               exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
